display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit 7-segment display. It holds a 16-bit hex value and 4 decimal points, and shares one internal hex-to-segment decoder across the four digits. It steps a one-hot digit enable through digits 0..3 with an anti-ghosting blank interval in each slot. New values commit only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between datapath result registers and the physical display, or the `sim_display`/`sim_b7seg` models in simulation.

---
 rtl/display_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller with frame-synchronous value commit.
// Optional leading-zero blanking is enabled by defining DISP_LZB_EN.
module display_scan_ctrl #(
    parameter int PRESCALE = 4,
    parameter int BLANK    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  digit,
    output logic        frame,
    output logic        upd_ack
);

    localparam int             CW      = $clog2(PRESCALE);
    localparam logic [CW-1:0]  CNT_MAX = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_BLANK, PH_DRIVE} phase_t;

    logic [CW-1:0] cnt_q;
    logic [1:0]    slot_q;
    logic [15:0]   disp_val_q, pend_val_q;
    logic [3:0]    disp_dp_q, pend_dp_q;
    logic          pend_q;

    logic          boundary, commit, lz_blank;
    logic [3:0]    nibble;
    phase_t        phase;
    logic [7:0]    seg_next;
    logic [3:0]    an_next;
    logic [1:0]    digit_next;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign boundary = en && (cnt_q == CNT_MAX) && (slot_q == 2'd3);
    // Disabled scanning has no frame in flight, so a pending value commits at once.
    assign commit   = pend_q && (boundary || !en);
    assign nibble   = disp_val_q[{slot_q, 2'b00} +: 4];

`ifdef DISP_LZB_EN
    always_comb begin
        case (slot_q)
            2'd3:    lz_blank = (disp_val_q[15:12] == 4'h0);
            2'd2:    lz_blank = (disp_val_q[15:8]  == 8'h00);
            2'd1:    lz_blank = (disp_val_q[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        if (!en)                    phase = PH_IDLE;
        else if (int'(cnt_q) < BLANK) phase = PH_BLANK;
        else                        phase = PH_DRIVE;
    end

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        seg_next   = 8'h00;
        an_next    = 4'h0;
        digit_next = en ? slot_q : 2'd0;
        if (phase == PH_DRIVE) begin
            an_next  = 4'b0001 << slot_q;
            seg_next = {disp_dp_q[slot_q], lz_blank ? 7'h00 : hex7(nibble)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            slot_q     <= 2'd0;
            disp_val_q <= 16'h0000;
            disp_dp_q  <= 4'h0;
            pend_val_q <= 16'h0000;
            pend_dp_q  <= 4'h0;
            pend_q     <= 1'b0;
            seg        <= 8'h00;
            an         <= 4'h0;
            digit      <= 2'd0;
            frame      <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            if (!en) begin
                cnt_q  <= '0;
                slot_q <= 2'd0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q  <= '0;
                slot_q <= slot_q + 2'd1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end

            if (commit) begin
                disp_val_q <= pend_val_q;
                disp_dp_q  <= pend_dp_q;
            end

            // A load in the commit cycle re-arms pend for the next boundary.
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp;
                pend_q     <= 1'b1;
            end else if (commit) begin
                pend_q     <= 1'b0;
            end

            seg     <= seg_next;
            an      <= an_next;
            digit   <= digit_next;
            frame   <= boundary;
            upd_ack <= commit;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (PRESCALE=4, BLANK=1); honours DISP_LZB_EN.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit;
    logic        frame, upd_ack;

    int checks   = 0;
    int failures = 0;

`ifdef DISP_LZB_EN
    localparam logic [31:0] ZERO_SEGS = 32'h00_00_00_3F;
    localparam logic [31:0] V0050_SEGS = 32'h00_00_6D_3F;
`else
    localparam logic [31:0] ZERO_SEGS = 32'h3F_3F_3F_3F;
    localparam logic [31:0] V0050_SEGS = 32'h3F_3F_6D_3F;
`endif

    display_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value), .dp(dp),
        .seg(seg), .an(an), .digit(digit), .frame(frame), .upd_ack(upd_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered right after a boundary sample; the final sample is the next boundary.
    task automatic check_frame(input string tag, input logic [31:0] segs, input logic ack_last);
        for (int i = 0; i < 16; i++) begin
            int slot;
            logic drive;
            @(negedge clk);
            slot  = i / 4;
            drive = (i % 4) != 0;
            check({tag, "_an"},    an,      drive ? 32'(4'b0001 << slot) : 32'h0);
            check({tag, "_seg"},   seg,     drive ? 32'(segs[8*slot +: 8]) : 32'h0);
            check({tag, "_digit"}, digit,   32'(slot));
            check({tag, "_frame"}, frame,   32'(i == 15));
            check({tag, "_ack"},   upd_ack, 32'((i == 15) && ack_last));
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0000; dp = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {seg, an, digit, frame, upd_ack}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {seg, an, digit, frame, upd_ack}, 32'h0);

        // Basic scan from enable
        en = 1'b1;
        check_frame("scan0", ZERO_SEGS, 1'b0);

        // Commit at frame boundary
        value = 16'h1234; dp = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (n < 40 && upd_ack !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", upd_ack, 32'h1);
        check("ack_latency_ok", 32'(n <= 18), 32'h1);
        check("ack_with_frame", frame, 32'h1);
        check("old_seg_at_ack", seg, 32'(ZERO_SEGS[31:24]));
        check_frame("v1234", 32'h06_DB_4F_66, 1'b0);

        // Back-to-back loads: last write wins, one ack
        value = 16'hAAAA; dp = 4'h0; load = 1'b1;
        @(negedge clk);
        check("b2b_no_early_ack", upd_ack, 32'h0);
        value = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        for (int i = 2; i < 16; i++) @(negedge clk);
        check("b2b_ack", upd_ack, 32'h1);
        check_frame("v5555", 32'h6D_6D_6D_6D, 1'b0);

        // Load coincident with the boundary edge
        value = 16'h7777; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (14) @(negedge clk);
        value = 16'h8888; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("coinc_ack1", upd_ack, 32'h1);
        check("coinc_frame", frame, 32'h1);
        check("coinc_old_seg", seg, 32'h6D);
        check_frame("v7777", 32'h07_07_07_07, 1'b1);
        check_frame("v8888", 32'h7F_7F_7F_7F, 1'b0);

        // Enable drop mid-slot, idle commit, re-enable at slot 0
        repeat (6) @(negedge clk);
        check("pre_drop_an", an, 32'h2);
        en = 1'b0;
        @(negedge clk);
        check("drop_an", an, 32'h0);
        check("drop_seg", seg, 32'h0);
        check("drop_digit", digit, 32'h0);
        value = 16'h0050; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("idle_no_ack_yet", upd_ack, 32'h0);
        @(negedge clk);
        check("idle_ack", upd_ack, 32'h1);
        check("idle_no_frame", frame, 32'h0);
        @(negedge clk);
        check("idle_ack_1cyc", upd_ack, 32'h0);
        en = 1'b1;
        check_frame("v0050", V0050_SEGS, 1'b0);

        // Asynchronous reset mid-frame discards pending value
        value = 16'h9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_an", an, 32'h2);
        #2 rst_n = 1'b0;
        #1 check("async_rst_outputs", {seg, an, digit, frame, upd_ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame("post_rst", ZERO_SEGS, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
